// File: rtl/fetch_queue_stage.sv
// Fetch stage: sequential PC generation, one-cycle imem, prefetch queue
// with writeback/execute redirect and flush of queued and in-flight work.
module fetch_queue_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              wb_redirect,
  input  logic [ADDR_W-1:0] wb_target,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus_1_out
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIM = QDEPTH[CW:0];

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic [DATA_W-1:0] r_q_inst [QDEPTH];
  logic [ADDR_W-1:0] r_q_pc   [QDEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_target;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CW:0]       w_occ;
  logic [CW:0]       w_lim;

  always_comb begin
    w_redirect = wb_redirect | ex_redirect;
    w_target   = wb_redirect ? wb_target : ex_target;
  end

  // Reset also hides the head so a mid-stream reset never presents data
  always_comb begin
    w_valid = (r_count != '0) & ~w_redirect & ~rst;
    w_pop   = w_valid & out_ready;
    w_push  = r_inflight & ~w_redirect;
    w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    w_lim   = LIM + {{CW{1'b0}}, w_pop};
    w_issue = ~rst & ~w_redirect & (w_occ < w_lim);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        r_inflight_pc <= r_fetch_pc;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by r_count alone
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_inst[r_wr_ptr] <= imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

  always_comb begin
    imem_req      = w_issue;
    imem_addr     = r_fetch_pc;
    out_valid     = w_valid;
    inst_out      = r_q_inst[r_rd_ptr];
    pc_out        = r_q_pc[r_rd_ptr];
    pc_plus_1_out = r_q_pc[r_rd_ptr] + ADDR_W'(1);
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: per-cycle vector table plus
// hand-written stall/full-queue redirect sequences.
module tb_fetch_queue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        wb_redirect;
  logic [15:0] wb_target;
  logic        ex_redirect;
  logic [15:0] ex_target;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus_1_out;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_rdata <= imem_addr ^ 16'hA5A5;

  fetch_queue_stage #(
    .DATA_W(16), .ADDR_W(16), .QDEPTH(4), .RESET_PC(16'h0010)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .wb_redirect(wb_redirect), .wb_target(wb_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .inst_out(inst_out), .pc_out(pc_out), .pc_plus_1_out(pc_plus_1_out)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        wb;
    logic [15:0] wbt;
    logic        ex;
    logic [15:0] ext;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy,
                       input logic wb, input logic [15:0] wbt,
                       input logic ex, input logic [15:0] ext);
    @(negedge clk);
    rst = r;
    out_ready = rdy;
    wb_redirect = wb;
    wb_target = wbt;
    ex_redirect = ex;
    ex_target = ext;
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [15:0] pc);
    chk({nm, " valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, " pc"}, {16'd0, pc_out}, {16'd0, pc});
    chk({nm, " inst"}, {16'd0, inst_out}, {16'd0, pc ^ 16'hA5A5});
    chk({nm, " pc1"}, {16'd0, pc_plus_1_out}, {16'd0, pc + 16'd1});
  endtask

  initial begin
    vec_t vq[$];
    int n_req;
    int k;
    bit seen;

    rst = 1'b1;
    out_ready = 1'b0;
    wb_redirect = 1'b0;
    wb_target = '0;
    ex_redirect = 1'b0;
    ex_target = '0;

    // rst rdy wb wbt ex ext | req addr vld pc
    vq.push_back('{1,1,0,16'h0,0,16'h0, 0,16'h0000, 0,16'h0000});
    vq.push_back('{1,1,0,16'h0,0,16'h0, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0010, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0011, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0012, 1,16'h0010});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0013, 1,16'h0011});
    vq.push_back('{0,0,0,16'h0,0,16'h0, 1,16'h0014, 1,16'h0012});
    vq.push_back('{0,0,0,16'h0,0,16'h0, 1,16'h0015, 1,16'h0012});
    vq.push_back('{0,0,0,16'h0,0,16'h0, 0,16'h0000, 1,16'h0012});
    vq.push_back('{0,0,0,16'h0,0,16'h0, 0,16'h0000, 1,16'h0012});
    vq.push_back('{0,0,0,16'h0,0,16'h0, 0,16'h0000, 1,16'h0012});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0016, 1,16'h0012});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0017, 1,16'h0013});
    vq.push_back('{0,1,0,16'h0,1,16'h0200, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0200, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0201, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0202, 1,16'h0200});
    vq.push_back('{0,1,1,16'h0300,1,16'h0400, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0300, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0301, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0302, 1,16'h0300});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0303, 1,16'h0301});
    vq.push_back('{0,1,0,16'h0,1,16'hFFFE, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'hFFFE, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'hFFFF, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0000, 1,16'hFFFE});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0001, 1,16'hFFFF});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0002, 1,16'h0000});
    vq.push_back('{1,1,0,16'h0,0,16'h0, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0010, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0011, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0012, 1,16'h0010});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0013, 1,16'h0011});
    vq.push_back('{0,0,1,16'h0500,0,16'h0, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0500, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0501, 0,16'h0000});
    vq.push_back('{0,1,0,16'h0,0,16'h0, 1,16'h0502, 1,16'h0500});

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].rdy, vq[i].wb, vq[i].wbt,
            vq[i].ex, vq[i].ext);
      chk($sformatf("r%0d req", i), {31'd0, imem_req}, {31'd0, vq[i].req});
      if (vq[i].req)
        chk($sformatf("r%0d addr", i), {16'd0, imem_addr},
            {16'd0, vq[i].addr});
      if (vq[i].vld)
        chk_head($sformatf("r%0d", i), vq[i].pc);
      else
        chk($sformatf("r%0d valid", i), {31'd0, out_valid}, 32'd0);
    end

    // Stall from an empty queue: exactly QDEPTH fetches, head stays put
    drive(0, 0, 0, 16'h0, 1, 16'h0700);
    chk("st redir req", {31'd0, imem_req}, 32'd0);
    n_req = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 16'h0, 0, 16'h0);
      if (imem_req) n_req++;
      if (out_valid)
        chk($sformatf("st c%0d pc", c), {16'd0, pc_out}, 32'h0700);
    end
    chk("st issues", n_req, 4);
    chk_head("st head", 16'h0700);

    // Redirect against a full queue: flush, first new head at t+3
    drive(0, 1, 0, 16'h0, 1, 16'h0800);
    chk("full redir valid", {31'd0, out_valid}, 32'd0);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 8) begin
      drive(0, 1, 0, 16'h0, 0, 16'h0);
      k++;
      seen = out_valid;
    end
    chk("full redir lat", k, 3);
    chk_head("full redir h0", 16'h0800);
    for (int j = 1; j < 4; j++) begin
      drive(0, 1, 0, 16'h0, 0, 16'h0);
      chk_head($sformatf("full redir h%0d", j), 16'h0800 + 16'(j));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
